// File: rtl/vga_text_renderer.sv
// 640x480@60 VGA text renderer: 80x30 cells of 8x16 glyphs, fed by a registered
// character RAM and font ROM, with a blinking block cursor overlay.
module vga_text_renderer #(
    parameter int         H_ACTIVE     = 640,
    parameter int         H_FRONT      = 16,
    parameter int         H_SYNC       = 96,
    parameter int         H_BACK       = 48,
    parameter int         V_ACTIVE     = 480,
    parameter int         V_FRONT      = 10,
    parameter int         V_SYNC       = 2,
    parameter int         V_BACK       = 33,
    parameter logic [2:0] FG_COLOR     = 3'b111,
    parameter logic [2:0] BG_COLOR     = 3'b000,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic        Clock,
    input  logic        Reset,
    output logic [11:0] CharAddress_o,
    input  logic [7:0]  CharData_i,
    output logic [10:0] FontAddress_o,
    input  logic [7:0]  FontData_i,
    input  logic [6:0]  CursorX_i,
    input  logic [4:0]  CursorY_i,
    output logic        Red_o,
    output logic        Green_o,
    output logic        Blue_o,
    output logic        HSync_o,
    output logic        VSync_o,
    output logic        FrameStart_o
);

    localparam int         H_TOTAL    = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int         V_TOTAL    = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int         COLS       = H_ACTIVE / 8;
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [9:0] h_q, h_d, v_q, v_d;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_vis_q, blink_vis_d;

    logic       active_s, hsync_raw_s, vsync_raw_s, cursor_hit_s, first_s;
    logic       glyph_valid_s, pixel_s, bit_s;
    logic [2:0] rgb_s;

    logic       active_p1_q, hsync_p1_q, vsync_p1_q, cursor_p1_q, first_p1_q;
    logic [2:0] hpix_p1_q;
    logic [3:0] vrow_p1_q;
    logic       active_p2_q, hsync_p2_q, vsync_p2_q, cursor_p2_q, first_p2_q;
    logic       glyph_valid_p2_q;
    logic [2:0] hpix_p2_q;
    logic [2:0] rgb_q;
    logic       hsync_q, vsync_q, frame_start_q;

    // Raster counters; blink phase advances only when the raster wraps to a new frame
    always_comb begin
        h_d         = h_q;
        v_d         = v_q;
        blink_cnt_d = blink_cnt_q;
        blink_vis_d = blink_vis_q;
        if (h_q == H_LAST) begin
            h_d = 10'd0;
            if (v_q == V_LAST) begin
                v_d = 10'd0;
                if (blink_cnt_q == BLINK_LAST) begin
                    blink_cnt_d = 8'd0;
                    blink_vis_d = ~blink_vis_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 8'd1;
                end
            end else begin
                v_d = v_q + 10'd1;
            end
        end else begin
            h_d = h_q + 10'd1;
        end
    end

    // Stage 0: character address and per-pixel attributes straight from the counters
    always_comb begin
        active_s     = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
        hsync_raw_s  = (h_q >= HS_START) && (h_q < HS_END);
        vsync_raw_s  = (v_q >= VS_START) && (v_q < VS_END);
        cursor_hit_s = (h_q[9:3] == CursorX_i) && (v_q[9:4] == {1'b0, CursorY_i});
        first_s      = (h_q == 10'd0) && (v_q == 10'd0);
        if (active_s) begin
            CharAddress_o = 12'(v_q[9:4]) * 12'(COLS) + 12'(h_q[9:3]);
        end else begin
            CharAddress_o = 12'd0;
        end
    end

    // Stage 1 and 2: glyph lookup, then pick the pixel bit and apply the cursor
    always_comb begin
        // code-32 modulo 128 only needs the low seven bits of the code
        FontAddress_o = {CharData_i[6:0] - 7'd32, vrow_p1_q};
        glyph_valid_s = (CharData_i >= 8'd32) && (CharData_i <= 8'd159);
        if (glyph_valid_p2_q) begin
            pixel_s = FontData_i[3'd7 - hpix_p2_q];
        end else begin
            pixel_s = 1'b0;
        end
        bit_s = pixel_s ^ (cursor_p2_q & blink_vis_q);
        if (active_p2_q) begin
            rgb_s = bit_s ? FG_COLOR : BG_COLOR;
        end else begin
            rgb_s = 3'b000;
        end
    end

    // All state: counters, blink, delay line and output registers
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            h_q              <= 10'd0;
            v_q              <= 10'd0;
            blink_cnt_q      <= 8'd0;
            blink_vis_q      <= 1'b1;
            active_p1_q      <= 1'b0;
            hsync_p1_q       <= 1'b0;
            vsync_p1_q       <= 1'b0;
            cursor_p1_q      <= 1'b0;
            first_p1_q       <= 1'b0;
            hpix_p1_q        <= 3'd0;
            vrow_p1_q        <= 4'd0;
            active_p2_q      <= 1'b0;
            hsync_p2_q       <= 1'b0;
            vsync_p2_q       <= 1'b0;
            cursor_p2_q      <= 1'b0;
            first_p2_q       <= 1'b0;
            glyph_valid_p2_q <= 1'b0;
            hpix_p2_q        <= 3'd0;
            rgb_q            <= 3'b000;
            hsync_q          <= 1'b1;
            vsync_q          <= 1'b1;
            frame_start_q    <= 1'b0;
        end else begin
            h_q              <= h_d;
            v_q              <= v_d;
            blink_cnt_q      <= blink_cnt_d;
            blink_vis_q      <= blink_vis_d;
            active_p1_q      <= active_s;
            hsync_p1_q       <= hsync_raw_s;
            vsync_p1_q       <= vsync_raw_s;
            cursor_p1_q      <= cursor_hit_s;
            first_p1_q       <= first_s;
            hpix_p1_q        <= h_q[2:0];
            vrow_p1_q        <= v_q[3:0];
            active_p2_q      <= active_p1_q;
            hsync_p2_q       <= hsync_p1_q;
            vsync_p2_q       <= vsync_p1_q;
            cursor_p2_q      <= cursor_p1_q;
            first_p2_q       <= first_p1_q;
            glyph_valid_p2_q <= glyph_valid_s;
            hpix_p2_q        <= hpix_p1_q;
            rgb_q            <= rgb_s;
            hsync_q          <= ~hsync_p2_q;
            vsync_q          <= ~vsync_p2_q;
            frame_start_q    <= first_p2_q;
        end
    end

    assign Red_o        = rgb_q[2];
    assign Green_o      = rgb_q[1];
    assign Blue_o       = rgb_q[0];
    assign HSync_o      = hsync_q;
    assign VSync_o      = vsync_q;
    assign FrameStart_o = frame_start_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// Self-checking bench for vga_text_renderer on a shrunken raster (96x56 total,
// 8x3 cells) so several frames and blink toggles fit in a short run.
module tb_vga_text_renderer;

    localparam int HA = 64, HF = 8, HSW = 16, HB = 8;
    localparam int VA = 48, VF = 2, VSW = 2, VB = 4;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FT = HT * VT;
    localparam int BF = 3;
    localparam int COLS = HA / 8;
    localparam logic [2:0] FG = 3'b111;
    localparam logic [2:0] BG = 3'b000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] char_addr;
    logic [7:0]  char_data = 8'd0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = 8'd0;
    logic [6:0]  cursor_x = 7'd100;
    logic [4:0]  cursor_y = 5'd31;
    logic        red, green, blue, hsync, vsync, frame_start;

    logic [7:0] ram [0:4095];
    logic [7:0] rom [0:2047];

    int checks = 0, passes = 0, k = 0;
    int cx = 100, cy = 31;
    int cxh [4];
    int cyh [4];
    int hs_fall1, hs_fall2, hs_rise1, vs_fall1, vs_rise1, fs1, fs2;
    logic prev_hs, prev_vs;

    vga_text_renderer #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .FG_COLOR(FG), .BG_COLOR(BG), .BLINK_FRAMES(BF)
    ) dut (
        .Clock(clk), .Reset(rst_n),
        .CharAddress_o(char_addr), .CharData_i(char_data),
        .FontAddress_o(font_addr), .FontData_i(font_data),
        .CursorX_i(cursor_x), .CursorY_i(cursor_y),
        .Red_o(red), .Green_o(green), .Blue_o(blue),
        .HSync_o(hsync), .VSync_o(vsync), .FrameStart_o(frame_start)
    );

    always #20 clk = ~clk;

    // Registered-read memory models
    always @(posedge clk) begin
        char_data <= ram[char_addr];
        font_data <= rom[font_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
        end
    endtask

    // What the display should show for raster index j, from the raster rules
    function automatic void model(input int j, input int mcx, input int mcy,
                                  output logic [2:0] rgb, output logic hs, output logic vs,
                                  output logic fs, output logic [11:0] addr, output logic [10:0] faddr);
        int h, v, f;
        logic [7:0] code, row;
        logic act, bitv, cur, vis;
        h = j % HT;
        v = (j / HT) % VT;
        f = j / FT;
        act = (h < HA) && (v < VA);
        addr = act ? 12'((v / 16) * COLS + h / 8) : 12'd0;
        code = ram[addr];
        faddr = 11'((((int'(code) - 32) & 127) * 16) + (v % 16));
        row = rom[faddr];
        bitv = (code >= 8'd32 && code <= 8'd159) ? row[7 - (h % 8)] : 1'b0;
        cur = (h / 8 == mcx) && (v / 16 == mcy);
        vis = ((f / BF) % 2) == 0;
        rgb = !act ? 3'b000 : ((bitv ^ (cur && vis)) ? FG : BG);
        hs = !(h >= HA + HF && h < HA + HF + HSW);
        vs = !(v >= VA + VF && v < VA + VF + VSW);
        fs = (h == 0) && (v == 0);
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_rgb"}, 32'({red, green, blue}), 32'd0);
        check_eq({tag, "_hs"}, 32'(hsync), 32'd1);
        check_eq({tag, "_vs"}, 32'(vsync), 32'd1);
        check_eq({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    // Asynchronous reset mid-cycle, then release on a falling edge (raster index 0)
    task automatic do_reset();
        @(negedge clk);
        #7 rst_n = 1'b0;
        #1 check_reset_outputs("in_reset");
        check_eq("in_reset_addr", 32'(char_addr), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1;
        vs_fall1 = -1; vs_rise1 = -1; fs1 = -1; fs2 = -1;
        prev_hs = 1'b1; prev_vs = 1'b1;
    endtask

    task automatic run(input int n, input bit rnd_cursor);
        logic [2:0] e_rgb;
        logic e_hs, e_vs, e_fs;
        logic [11:0] e_addr, d_addr;
        logic [10:0] e_fa, d_fa;
        for (int i = 0; i < n; i++) begin
            if (rnd_cursor && $urandom_range(0, 299) == 0) begin
                cx = int'($urandom_range(0, 9));
                cy = int'($urandom_range(0, 3));
                cursor_x = 7'(cx);
                cursor_y = 5'(cy);
            end
            cxh[k % 4] = cx;
            cyh[k % 4] = cy;
            model(k, cx, cy, e_rgb, e_hs, e_vs, e_fs, e_addr, d_fa);
            check_eq("char_addr", 32'(char_addr), 32'(e_addr));
            if (k >= 1) begin
                model(k - 1, 0, 0, e_rgb, e_hs, e_vs, e_fs, d_addr, e_fa);
                check_eq("font_addr", 32'(font_addr), 32'(e_fa));
            end
            if (k >= 3) begin
                model(k - 3, cxh[(k - 3) % 4], cyh[(k - 3) % 4], e_rgb, e_hs, e_vs, e_fs, d_addr, d_fa);
                check_eq("rgb", 32'({red, green, blue}), 32'(e_rgb));
                check_eq("hsync", 32'(hsync), 32'(e_hs));
                check_eq("vsync", 32'(vsync), 32'(e_vs));
                check_eq("frame_start", 32'(frame_start), 32'(e_fs));
            end else begin
                check_reset_outputs("pipe_fill");
            end
            if (prev_hs && !hsync) begin
                if (hs_fall1 < 0) hs_fall1 = k;
                else if (hs_fall2 < 0) hs_fall2 = k;
            end
            if (!prev_hs && hsync && hs_rise1 < 0) hs_rise1 = k;
            if (prev_vs && !vsync && vs_fall1 < 0) vs_fall1 = k;
            if (!prev_vs && vsync && vs_rise1 < 0) vs_rise1 = k;
            if (frame_start) begin
                if (fs1 < 0) fs1 = k;
                else if (fs2 < 0) fs2 = k;
            end
            prev_hs = hsync;
            prev_vs = vsync;
            k++;
            @(negedge clk);
        end
    endtask

    initial begin
        // Glyph 'A' everywhere with row byte 0x81, cursor out of range
        for (int a = 0; a < 4096; a++) ram[a] = 8'h41;
        for (int a = 0; a < 2048; a++) rom[a] = 8'h81;
        do_reset();
        run(FT + 200, 1'b0);
        check_eq("hs_first_fall", 32'(hs_fall1), 32'(HA + HF + 3));
        check_eq("hs_low_len", 32'(hs_rise1 - hs_fall1), 32'(HSW));
        check_eq("hs_period", 32'(hs_fall2 - hs_fall1), 32'(HT));
        check_eq("vs_first_fall", 32'(vs_fall1), 32'((VA + VF) * HT + 3));
        check_eq("vs_low_len", 32'(vs_rise1 - vs_fall1), 32'(VSW * HT));

        // Codes outside the font range render as background
        for (int a = 0; a < 4096; a++) ram[a] = ($urandom_range(0, 1) == 0) ? 8'h10 : 8'hC0;
        for (int a = 0; a < 2048; a++) rom[a] = 8'hFF;
        do_reset();
        run(FT + 10, 1'b0);

        // Blinking cursor on blank cells, across several blink phases
        for (int a = 0; a < 4096; a++) ram[a] = 8'h20;
        for (int a = 0; a < 2048; a++) rom[a] = 8'h00;
        cx = 5; cy = 2;
        cursor_x = 7'd5;
        cursor_y = 5'd2;
        do_reset();
        run(FT * (2 * BF + 1) + 10, 1'b0);
        check_eq("fs_first", 32'(fs1), 32'd3);
        check_eq("fs_period", 32'(fs2 - fs1), 32'(FT));

        // Random contents and moving cursor, then a mid-line reset
        for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
        for (int a = 0; a < 2048; a++) rom[a] = 8'($urandom);
        do_reset();
        run(2 * FT + 137, 1'b1);
        do_reset();
        run(3 * HT, 1'b1);
        check_eq("restart_hs_fall", 32'(hs_fall1), 32'(HA + HF + 3));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
